// File: rtl/ripple_cla16_pkg.sv
// Shared definitions for the multi-cycle ripple-of-CLA adder.
// Holds default geometry, the derived block-index width and the FSM state type.
// Optional feature macro used by the top: RIPPLE_CLA16_OVF_EN (adds ovf output).
package ripple_cla16_pkg;

  localparam int unsigned WIDTH_DEF   = 16;
  localparam int unsigned BLK_W_DEF   = 4;
  localparam int unsigned NUM_BLK_DEF = WIDTH_DEF / BLK_W_DEF;
  localparam int unsigned IDX_W_DEF   = $clog2(NUM_BLK_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla4_block.sv
// Combinational carry-lookahead block (default 4 bits).
// Ports:
//   a, b    : operand slices
//   cin     : carry into the block
//   sum     : a + b + cin (block width)
//   cout    : carry out of the block
//   grp_p   : group propagate (all bits propagate)
//   grp_g   : group generate (block generates a carry regardless of cin)
// Every internal carry is a flat sum-of-products of g/p/cin; nothing ripples.
module cla4_block #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         grp_p,
  output logic         grp_g
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, expanded per bit.
  always_comb begin
    logic gen_t;
    logic prop_t;
    gen_t  = 1'b0;
    prop_t = 1'b0;
    g      = a & b;
    p      = a ^ b;
    c      = '0;
    c[0]   = cin;
    grp_g  = 1'b0;
    grp_p  = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      gen_t  = g[i];
      prop_t = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gen_t  = gen_t | (prop_t & g[j]);
        prop_t = prop_t & p[j];
      end
      c[i+1] = gen_t | (prop_t & cin);
      if (i == int'(W) - 1) begin
        grp_g = gen_t;
        grp_p = prop_t;
      end
    end
    sum  = p ^ c[W-1:0];
    cout = c[W];
  end

endmodule

// File: rtl/ripple_cla16_adder.sv
// Multi-cycle adder: {c_out, Output} = A + B + c_in, one CLA block per clock,
// low block first. Operands are captured on the edge that sees en rise from IDLE.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : level request; high starts/keeps the add, low aborts or releases
//   A, B, c_in : operands (sampled once at start)
//   Output     : sum (modulo 2^WIDTH)
//   c_out      : carry out of the top block
//   ready      : result valid, held while en stays high
//   ovf        : signed overflow (only when RIPPLE_CLA16_OVF_EN is defined)
module ripple_cla16_adder
  import ripple_cla16_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned BLK_W = BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ready
`ifdef RIPPLE_CLA16_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NUM_BLK = WIDTH / BLK_W;
  localparam int unsigned IDX_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             c_out_q, c_out_d;
  logic             ready_q, ready_d;
`ifdef RIPPLE_CLA16_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [BLK_W-1:0] blk_a, blk_b, blk_sum;
  logic             blk_cout, blk_p, blk_g;
  logic             unused_grp;

  // Single shared block, fed the operand slice selected by idx.
  always_comb begin
    blk_a = a_q[idx_q*BLK_W +: BLK_W];
    blk_b = b_q[idx_q*BLK_W +: BLK_W];
  end

  cla4_block #(.W(BLK_W)) u_cla (
    .a     (blk_a),
    .b     (blk_b),
    .cin   (carry_q),
    .sum   (blk_sum),
    .cout  (blk_cout),
    .grp_p (blk_p),
    .grp_g (blk_g)
  );

  // Group P/G are available for a wider lookahead tier; not needed in ripple order.
  assign unused_grp = blk_p ^ blk_g;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    out_d   = out_q;
    c_out_d = c_out_q;
    ready_d = ready_q;
`ifdef RIPPLE_CLA16_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (en) begin
          a_d     = A;
          b_d     = B;
          carry_d = c_in;
          idx_d   = '0;
          out_d   = '0;
`ifdef RIPPLE_CLA16_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        if (!en) begin
          // Abort: partial sum stays visible but ready never rises.
          ready_d = 1'b0;
          state_d = IDLE;
        end else begin
          out_d[idx_q*BLK_W +: BLK_W] = blk_sum;
          carry_d = blk_cout;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            c_out_d = blk_cout;
            ready_d = 1'b1;
`ifdef RIPPLE_CLA16_OVF_EN
            ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (blk_sum[BLK_W-1] != a_q[WIDTH-1]);
`endif
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!en) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      c_out_q <= 1'b0;
      ready_q <= 1'b0;
`ifdef RIPPLE_CLA16_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      c_out_q <= c_out_d;
      ready_q <= ready_d;
`ifdef RIPPLE_CLA16_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Output = out_q;
  assign c_out  = c_out_q;
  assign ready  = ready_q;
`ifdef RIPPLE_CLA16_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_cla16_adder.sv
// Self-checking bench for ripple_cla16_adder: directed corner cases plus
// random operands checked against an integer-arithmetic reference.
module tb_ripple_cla16_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic [15:0] out;
  logic        c_out;
  logic        ready;
`ifdef RIPPLE_CLA16_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_cla16_adder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .A      (a),
    .B      (b),
    .c_in   (ci),
    .Output (out),
    .c_out  (c_out),
    .ready  (ready)
`ifdef RIPPLE_CLA16_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // Reference: full-precision integer sum.
  function automatic logic [16:0] model_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
    int unsigned s;
    s = int'(x) + int'(y) + int'(c);
    return 17'(s);
  endfunction

  // Reference: signed result outside 16-bit two's-complement range.
  function automatic logic model_ovf(input logic [15:0] x, input logic [15:0] y,
                                     input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    @(negedge clk);
    a  = ta;
    b  = tb_v;
    ci = tc;
    en = 1'b1;
  endtask

  // Returns number of negedges until ready seen, -1 if not within bound.
  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic end_op;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0 || c_out !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_init out=%h c_out=%b ready=%b exp 0000/0/0", out, c_out, ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset in the middle of CALC, between clock edges.
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0 || c_out !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_calc out=%h c_out=%b ready=%b exp 0000/0/0", out, c_out, ready);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b exp 0", ready);
    end
  endtask

  task automatic test_basic_hold;
    int cyc;
    start_op(16'd127, 16'd127, 1'b0);
    wait_ready(cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL basic_latency negedges=%0d exp 5", cyc);
    end
    checks++;
    if (out !== 16'd254 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum out=%0d c_out=%b exp 254/0", out, c_out);
    end
    // Held en never restarts, even with new operands.
    a = 16'h1234;
    b = 16'h4321;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || out !== 16'd254 || c_out !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold k=%0d ready=%b out=%0d exp 1/254", k, ready, out);
      end
    end
    end_op();
    checks++;
    if (ready !== 1'b0 || out !== 16'd254) begin
      errors++;
      $display("FAIL basic_release ready=%b out=%0d exp 0/254", ready, out);
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] ta [2];
    logic [15:0] tb_v [2];
    logic        tc [2];
    logic [16:0] exp_s;
    int          cyc;
    ta[0] = 16'hFFFF; tb_v[0] = 16'h0001; tc[0] = 1'b0;
    ta[1] = 16'h7FFF; tb_v[1] = 16'h0000; tc[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_s = model_sum(ta[i], tb_v[i], tc[i]);
      start_op(ta[i], tb_v[i], tc[i]);
      wait_ready(cyc);
      checks++;
      if (cyc != 5 || out !== exp_s[15:0] || c_out !== exp_s[16]) begin
        errors++;
        $display("FAIL boundary_%0d cyc=%0d out=%h c_out=%b exp 5/%h/%b",
                 i, cyc, out, c_out, exp_s[15:0], exp_s[16]);
      end
`ifdef RIPPLE_CLA16_OVF_EN
      checks++;
      if (ovf !== model_ovf(ta[i], tb_v[i], tc[i])) begin
        errors++;
        $display("FAIL boundary_ovf_%0d ovf=%b exp %b", i, ovf, model_ovf(ta[i], tb_v[i], tc[i]));
      end
`endif
      end_op();
    end
  endtask

  task automatic test_abort_restart;
    int cyc;
    int seen;
    start_op(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    en   = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_ready ready_high_cycles=%0d exp 0", seen);
    end
    start_op(16'h0F0F, 16'hF0F1, 1'b0);
    wait_ready(cyc);
    checks++;
    if (cyc != 5 || out !== 16'h0000 || c_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart cyc=%0d out=%h c_out=%b exp 5/0000/1", cyc, out, c_out);
    end
    end_op();
  endtask

  task automatic test_operand_change;
    int cyc;
    start_op(16'd127, 16'd127, 1'b0);
    @(negedge clk);
    a  = 16'd5;
    b  = 16'hAAAA;
    ci = 1'b1;
    wait_ready(cyc);
    checks++;
    if (cyc != 4 || out !== 16'd254 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL opchange cyc=%0d out=%0d c_out=%b exp 4/254/0", cyc, out, c_out);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || out !== 16'd254) begin
      errors++;
      $display("FAIL opchange_release ready=%b out=%0d exp 0/254", ready, out);
    end
  endtask

  task automatic test_random;
    logic [15:0] ta;
    logic [15:0] tb_v;
    logic        tc;
    logic [16:0] exp_s;
    int          cyc;
    for (int i = 0; i < 25; i++) begin
      ta    = 16'($urandom);
      tb_v  = 16'($urandom);
      tc    = 1'($urandom_range(0, 1));
      exp_s = model_sum(ta, tb_v, tc);
      start_op(ta, tb_v, tc);
      wait_ready(cyc);
      checks++;
      if (cyc != 5 || out !== exp_s[15:0] || c_out !== exp_s[16]) begin
        errors++;
        $display("FAIL random_%0d %h+%h+%b cyc=%0d out=%h c_out=%b exp 5/%h/%b",
                 i, ta, tb_v, tc, cyc, out, c_out, exp_s[15:0], exp_s[16]);
      end
`ifdef RIPPLE_CLA16_OVF_EN
      checks++;
      if (ovf !== model_ovf(ta, tb_v, tc)) begin
        errors++;
        $display("FAIL random_ovf_%0d ovf=%b exp %b", i, ovf, model_ovf(ta, tb_v, tc));
      end
`endif
      end_op();
    end
  endtask

  initial begin
    test_reset();
    test_basic_hold();
    test_boundaries();
    test_abort_restart();
    test_operand_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
